// File: rtl/cla_serial_adder_ctrl.sv
// rtl/cla_serial_adder_ctrl.sv - nibble-serial WIDTH-bit adder sharing one cla_4bits slice
// Optional subtract mode (sub port, B inverted, carry forced to 1) when CLA_SUB_EN is defined.

module cla_4bits (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic [3:0] c
);
   logic [3:0] g;
   logic [3:0] p;

   assign g = a & b;
   assign p = a ^ b;

   // c[i] is the carry out of bit i, all computed directly from g/p/cin
   assign c[0] = g[0] | (p[0] & cin);
   assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (&p & cin);
   assign s    = p ^ {c[2:0], cin};
endmodule

module cla_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CLA_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NSLICE = WIDTH / 4;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [IW-1:0]    idx;
   logic             last;
   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic [3:0]       slice_s;
   logic [3:0]       slice_c;
   logic [WIDTH-1:0] s_top;
   logic             unused_c;

`ifdef CLA_SUB_EN
   assign b_load = sub ? ~b : b;
   assign c_load = sub | cin;
`else
   assign b_load = b;
   assign c_load = cin;
`endif

   cla_4bits u_slice (
      .a   (a_sh[3:0]),
      .b   (b_sh[3:0]),
      .cin (carry),
      .s   (slice_s),
      .c   (slice_c)
   );

   assign unused_c = ^slice_c[1:0];
   assign last     = (idx == IW'(NSLICE - 1));
   // each slice result enters at the top so the LS nibble ends up at bit 0
   assign s_top    = WIDTH'(slice_s) << (WIDTH - 4);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN:     if (last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_sh      <= '0;
         b_sh      <= '0;
         carry     <= 1'b0;
         idx       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_nx == DONE);
         case (state)
            IDLE: if (in_valid) begin
               a_sh  <= a;
               b_sh  <= b_load;
               carry <= c_load;
               idx   <= '0;
            end
            RUN: begin
               sum   <= s_top | (sum >> 4);
               a_sh  <= a_sh >> 4;
               b_sh  <= b_sh >> 4;
               carry <= slice_c[3];
               if (last) begin
                  cout <= slice_c[3];
                  ovf  <= slice_c[2] ^ slice_c[3];
               end else begin
                  idx  <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// tb/tb_cla_serial_adder_ctrl.sv - directed vector bench for cla_serial_adder_ctrl (WIDTH 16 and 4)
// Subtract vectors are included when CLA_SUB_EN is defined.

module tb_cla_serial_adder_ctrl;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
`ifdef CLA_SUB_EN
   logic        sub = 1'b0;
   logic        sub4 = 1'b0;
`endif

   logic        in_valid4 = 1'b0;
   logic        in_ready4;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic        cin4 = 1'b0;
   logic        out_valid4;
   logic        out_ready4 = 1'b1;
   logic [3:0]  sum4;
   logic        cout4;
   logic        ovf4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cla_serial_adder_ctrl #(.WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef CLA_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   cla_serial_adder_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4),
`ifdef CLA_SUB_EN
      .sub(sub4),
`endif
      .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one full transaction on the 16-bit instance with out_ready held high
   task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic [15:0] es, input logic ec, input logic eo);
      int n;
      @(negedge clk);
      chk({name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
      a = av; b = bv; cin = ci; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({name, ".in_ready_fall"}, 32'(in_ready), 32'd0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk({name, ".latency"}, 32'(n), 32'd4);
      chk({name, ".sum"}, 32'(sum), 32'(es));
      chk({name, ".cout"}, 32'(cout), 32'(ec));
      chk({name, ".ovf"}, 32'(ovf), 32'(eo));
      @(posedge clk);
      @(negedge clk);
      chk({name, ".release"}, {30'd0, in_ready, out_valid}, 32'b10);
   endtask

   task automatic run_op4(input string name, input logic [3:0] av, input logic [3:0] bv,
                          input logic [3:0] es, input logic ec, input logic eo);
      int n;
      @(negedge clk);
      a4 = av; b4 = bv; cin4 = 1'b0; in_valid4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid4 = 1'b0;
      n = 0;
      while (!out_valid4 && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk({name, ".latency"}, 32'(n), 32'd1);
      chk({name, ".result"}, {26'd0, sum4, cout4, ovf4}, {26'd0, es, ec, eo});
      @(posedge clk);
      @(negedge clk);
      chk({name, ".release"}, {30'd0, in_ready4, out_valid4}, 32'b10);
   endtask

   initial begin
      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[5] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0};
      vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[7] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.state", {11'd0, in_ready, out_valid, cout, ovf, sum}, {11'd0, 4'b1000, 16'h0000});
      reset_n = 1'b1;
      @(negedge clk);
      chk("reset.after", {11'd0, in_ready, out_valid, cout, ovf, sum}, {11'd0, 4'b1000, 16'h0000});

      for (int i = 0; i < 8; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].s, vecs[i].co, vecs[i].ov);

      // output backpressure: result must hold and new operands must be refused
      begin
         int n;
         out_ready = 1'b0;
         @(negedge clk);
         a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         n = 0;
         while (!out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
         end
         chk("bp.latency", 32'(n), 32'd4);
         for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp.hold%0d", k), {12'd0, out_valid, in_ready, cout, ovf, sum},
                {12'd0, 4'b1000, 16'h3333});
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk("bp.release", {30'd0, in_ready, out_valid}, 32'b10);
      end

      // asynchronous reset in the second RUN cycle
      @(negedge clk);
      a = 16'h1111; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst_mid.outs", {14'd0, out_valid, in_ready, sum}, {14'd0, 2'b01, 16'h0000});
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid.no_out", 32'(out_valid), 32'd0);
      run_op("rst_mid.next", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

`ifdef CLA_SUB_EN
      sub = 1'b1;
      run_op("sub0", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      sub = 1'b0;
`endif

      run_op4("w4_a", 4'h9, 4'h8, 4'h1, 1'b1, 1'b1);
      run_op4("w4_b", 4'h7, 4'h1, 4'h8, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
